// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - 32-bit multi-cycle restoring divider for DIV/DIVU
module div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] operand_1_i,
  input  logic [31:0] operand_2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  // Working registers: r_quo starts as |dividend| and its MSBs are shifted
  // out into the remainder while quotient bits shift in at the LSB.
  logic [5:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvs;
  logic        r_signed;
  logic        r_sign1;
  logic        r_sign2;
  logic [63:0] r_result;

  logic        w_accept;
  logic        w_neg1;
  logic        w_neg2;
  logic [31:0] w_mag1;
  logic [31:0] w_mag2;
  logic [32:0] w_trial;
  logic [31:0] w_diff;
  logic        w_qbit;
  logic        w_cnt_done;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;

  assign w_accept   = start_i & ~annul_i;

  // Magnitudes of the operands; only negative values in signed mode flip.
  assign w_neg1     = signed_div_i & operand_1_i[31];
  assign w_neg2     = signed_div_i & operand_2_i[31];
  assign w_mag1     = w_neg1 ? (~operand_1_i + 32'd1) : operand_1_i;
  assign w_mag2     = w_neg2 ? (~operand_2_i + 32'd1) : operand_2_i;

  // 33-bit partial remainder after shifting in the next dividend bit.
  // The remainder is always below the divisor, so it fits back in 32 bits.
  assign w_trial    = {r_rem, r_quo[31]};
  assign w_qbit     = (w_trial >= {1'b0, r_dvs});
  assign w_diff     = w_trial[31:0] - r_dvs;
  assign w_cnt_done = (r_cnt == 6'd32);

  // Quotient sign follows operand sign mismatch, remainder follows dividend.
  assign w_quo_fix  = (r_signed & (r_sign1 ^ r_sign2)) ? (~r_quo + 32'd1) : r_quo;
  assign w_rem_fix  = (r_signed & r_sign1) ? (~r_rem + 32'd1) : r_rem;

  assign result_o   = r_result;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and status outputs
  always_comb begin
    w_state_next = r_state;
    busy_o       = 1'b0;
    ready_o      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = (operand_2_i == 32'd0) ? S_BYZERO : S_ON;
        end
      end
      S_BYZERO: begin
        busy_o       = 1'b1;
        w_state_next = annul_i ? S_IDLE : S_END;
      end
      S_ON: begin
        busy_o = 1'b1;
        if (annul_i) begin
          w_state_next = S_IDLE;
        end else if (w_cnt_done) begin
          w_state_next = S_END;
        end
      end
      S_END: begin
        ready_o = 1'b1;
        if (!start_i) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Operand capture, iteration datapath and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= 6'd0;
      r_rem    <= 32'd0;
      r_quo    <= 32'd0;
      r_dvs    <= 32'd0;
      r_signed <= 1'b0;
      r_sign1  <= 1'b0;
      r_sign2  <= 1'b0;
      r_result <= 64'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_result <= 64'd0;
          if (w_accept && (operand_2_i != 32'd0)) begin
            r_signed <= signed_div_i;
            r_sign1  <= operand_1_i[31];
            r_sign2  <= operand_2_i[31];
            r_quo    <= w_mag1;
            r_dvs    <= w_mag2;
            r_rem    <= 32'd0;
            r_cnt    <= 6'd0;
          end
        end
        S_ON: begin
          if (annul_i) begin
            r_cnt    <= 6'd0;
            r_rem    <= 32'd0;
            r_quo    <= 32'd0;
            r_dvs    <= 32'd0;
            r_result <= 64'd0;
          end else if (!w_cnt_done) begin
            r_rem <= w_qbit ? w_diff : w_trial[31:0];
            r_quo <= {r_quo[30:0], w_qbit};
            r_cnt <= r_cnt + 6'd1;
          end else begin
            r_result <= {w_rem_fix, w_quo_fix};
          end
        end
        S_BYZERO: begin
          r_result <= 64'd0;
        end
        S_END: begin
          if (!start_i) begin
            r_result <= 64'd0;
          end
        end
        default: begin
          r_result <= 64'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - self-checking bench for div_ctrl
module tb_div_ctrl;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] operand_1_i;
  logic [31:0] operand_2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int checks;
  int failures;

  div_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .operand_1_i  (operand_1_i),
    .operand_2_i  (operand_2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer division, {remainder, quotient}
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int          sa;
    int          sb;
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return 64'd0;
    if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      q = 32'h80000000;
      r = 32'd0;
    end else begin
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
    end
    return {r, q};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one division from IDLE (called just after a negedge) and checks
  // latency, busy during the run, result, hold behaviour and return to IDLE.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string tag);
    int   n;
    int   lat;
    logic busy_bad;
    lat          = (b == 32'd0) ? 2 : 34;
    signed_div_i = sgn;
    operand_1_i  = a;
    operand_2_i  = b;
    start_i      = 1'b1;
    n            = 0;
    busy_bad     = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        operand_1_i  = $urandom;
        operand_2_i  = $urandom;
        signed_div_i = 1'($urandom_range(0, 1));
      end
      if (n < lat && busy_o !== 1'b1) busy_bad = 1'b1;
    end while (ready_o !== 1'b1 && n < 60);
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    chk({tag, "_busy"}, {63'd0, busy_bad}, 64'd0);
    chk({tag, "_result"}, result_o, exp);
    @(negedge clk);
    chk({tag, "_hold"}, {busy_o, ready_o, result_o}, {1'b0, 1'b1, exp});
    start_i = 1'b0;
    @(negedge clk);
    chk({tag, "_idle"}, {busy_o, ready_o, result_o}, {1'b0, 1'b0, 64'd0});
  endtask

  initial begin
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic        seen;
    int          n;

    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    signed_div_i = 1'b0;
    operand_1_i  = 32'd0;
    operand_2_i  = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;

    #1;
    chk("reset_state", {busy_o, ready_o, result_o}, {1'b0, 1'b0, 64'd0});
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed scenarios
    do_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, "divu_100_7");
    do_div(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, "div_m7_2");
    do_div(1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, "div_7_m2");
    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, "div_ovf");
    do_div(1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, "divu_ovf_ops");
    do_div(1'b0, 32'd55, 32'd0, 64'd0, "divu_by0");
    do_div(1'b1, 32'hFFFFFFF0, 32'd0, 64'd0, "div_by0");

    // Annul mid-ON, then a fresh division
    signed_div_i = 1'b0;
    operand_1_i  = 32'd1000;
    operand_2_i  = 32'd3;
    start_i      = 1'b1;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    chk("annul_on_idle", {busy_o, ready_o, result_o}, {1'b0, 1'b0, 64'd0});
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o !== 1'b0) seen = 1'b1;
    end
    chk("annul_no_ready", {63'd0, seen}, 64'd0);
    do_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, "divu_9_3");

    // Annul in BYZERO
    operand_1_i = 32'd5;
    operand_2_i = 32'd0;
    start_i     = 1'b1;
    @(negedge clk);
    chk("byzero_busy", {63'd0, busy_o}, 64'd1);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    chk("annul_byzero", {busy_o, ready_o, result_o}, {1'b0, 1'b0, 64'd0});

    // Annul ignored in END
    signed_div_i = 1'b0;
    operand_1_i  = 32'd100;
    operand_2_i  = 32'd7;
    start_i      = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ready_o !== 1'b1 && n < 60);
    chk("end_reach", 64'(n), 64'd34);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    chk("end_annul_ignored", {ready_o, result_o}, {1'b1, 64'h00000002_0000000E});
    start_i = 1'b0;
    @(negedge clk);

    // Asynchronous reset mid-ON
    signed_div_i = 1'b1;
    operand_1_i  = 32'hFFFF0000;
    operand_2_i  = 32'd77;
    start_i      = 1'b1;
    repeat (15) @(negedge clk);
    #2;
    rst     = 1'b1;
    start_i = 1'b0;
    #1;
    chk("async_rst", {busy_o, ready_o, result_o}, {1'b0, 1'b0, 64'd0});
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", {busy_o, ready_o, result_o}, {1'b0, 1'b0, 64'd0});
    do_div(1'b1, 32'hFFFF0000, 32'd77, ref_div(1'b1, 32'hFFFF0000, 32'd77), "post_rst_div");

    // Randomized operations against the reference model
    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 4))
        0: b = $urandom;
        1: b = $urandom_range(1, 15);
        2: b = 32'd0 - $urandom_range(1, 15);
        3: b = $urandom >> $urandom_range(0, 31);
        default: begin
          b = $urandom_range(0, 1) ? 32'd0 : 32'hFFFFFFFF;
          if ($urandom_range(0, 1) == 1) a = 32'h80000000;
        end
      endcase
      do_div(sgn, a, b, ref_div(sgn, a, b), $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
